// File: rtl/dth_pkg.sv
// dth_pkg: shared FSM state encoding and helper functions for the dth stream decoder.
package dth_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BODY = 2'b01, DROP = 2'b10} state_t;
    function automatic int flag_bit(input int data_width);
        return data_width;
    endfunction
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/dth_len_cnt.sv
// dth_len_cnt: frame length counter; clr with inc loads 1, term flags the last legal middle position.
module dth_len_cnt
    import dth_pkg::*;
#(
    parameter int MAX_LEN = 2048,
    parameter int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [LW-1:0] cnt,
    output logic          term
);
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (clr) cnt <= inc ? LW'(1) : '0;
        else if (inc) cnt <= cnt + LW'(1);
    assign term = cnt == LW'(MAX_LEN - 1);
endmodule

// File: rtl/dth.sv
// dth: delimiter-tagged stream decoder; strips the head/tail flag and emits sof/eof/len/abort/err one cycle later.
// Optional DTH_STATS_EN adds saturating good-frame and error counters.
module dth
    import dth_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN = 2048,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH:0]   iv_data,
    input  logic                  i_data_wr,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    output logic                  o_sof,
    output logic                  o_eof,
    output logic [LW-1:0]         ov_frame_len,
    output logic                  o_abort,
`ifdef DTH_STATS_EN
    output logic [15:0]           ov_frame_cnt,
    output logic [15:0]           ov_err_cnt,
`endif
    output logic                  o_err
);
    localparam int FB = flag_bit(DATA_WIDTH);
    state_t state, nxt;
    logic flag, emit, sof, eof, abort, err, clr, inc, term;
    logic [LW-1:0] cnt;
    assign flag = iv_data[FB];
    dth_len_cnt #(.MAX_LEN(MAX_LEN), .LW(LW)) u_len (
        .clk(i_clk), .rst(i_rst), .clr(clr), .inc(inc), .cnt(cnt), .term(term)
    );
    always_ff @(posedge i_clk) state <= i_rst ? IDLE : nxt;
    always_comb begin
        nxt = state;
        emit = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
        abort = 1'b0;
        err = 1'b0;
        clr = 1'b0;
        inc = 1'b0;
        case (state)
            IDLE: if (i_data_wr) begin
                nxt = flag ? BODY : DROP;
                emit = flag;
                sof = flag;
                clr = flag;
                inc = flag;
                err = !flag;
            end
            BODY: if (!i_data_wr) begin
                nxt = IDLE;
                abort = 1'b1;
                err = 1'b1;
            end else if (flag) begin
                nxt = IDLE;
                emit = 1'b1;
                eof = 1'b1;
                inc = 1'b1;
            end else if (term) begin
                nxt = DROP;
                abort = 1'b1;
                err = 1'b1;
            end else begin
                emit = 1'b1;
                inc = 1'b1;
            end
            DROP: nxt = i_data_wr ? DROP : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // ov_data and ov_frame_len hold their last value between updates
    always_ff @(posedge i_clk)
        if (i_rst) begin
            ov_data <= '0;
            ov_frame_len <= '0;
            o_data_wr <= 1'b0;
            o_sof <= 1'b0;
            o_eof <= 1'b0;
            o_abort <= 1'b0;
            o_err <= 1'b0;
        end else begin
            o_data_wr <= emit;
            o_sof <= sof;
            o_eof <= eof;
            o_abort <= abort;
            o_err <= err;
            if (emit) ov_data <= iv_data[DATA_WIDTH-1:0];
            if (eof) ov_frame_len <= cnt + LW'(1);
        end
`ifdef DTH_STATS_EN
    always_ff @(posedge i_clk)
        if (i_rst) begin
            ov_frame_cnt <= '0;
            ov_err_cnt <= '0;
        end else begin
            if (eof) ov_frame_cnt <= sat_inc16(ov_frame_cnt);
            if (err) ov_err_cnt <= sat_inc16(ov_err_cnt);
        end
`endif
endmodule

// File: tb/tb_dth.sv
// tb_dth: table-driven directed vectors plus randomized stream checked against a frame-level model.
module tb_dth;
    localparam int DW = 8, ML = 4, LW = 3;
    typedef struct packed {
        logic dwr, sof, eof, ab, er;
        logic [DW-1:0] data;
        logic [LW-1:0] len;
    } exp_t;
    typedef struct packed {
        logic rst, wr;
        logic [DW:0] d;
        exp_t e;
    } vec_t;
    logic i_clk = 1'b0, i_rst = 1'b1, i_data_wr = 1'b0;
    logic [DW:0] iv_data = '0;
    logic [DW-1:0] ov_data;
    logic o_data_wr, o_sof, o_eof, o_abort, o_err;
    logic [LW-1:0] ov_frame_len;
`ifdef DTH_STATS_EN
    logic [15:0] ov_frame_cnt, ov_err_cnt;
`endif
    int n_vec = 0, n_bad = 0;
    bit in_frame = 0, dropping = 0;
    int len = 0, m_fc = 0, m_ec = 0;
    exp_t m = '0;
    vec_t tbl[32];
    always #5 i_clk = ~i_clk;
    dth #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .iv_data(iv_data), .i_data_wr(i_data_wr),
        .ov_data(ov_data), .o_data_wr(o_data_wr), .o_sof(o_sof), .o_eof(o_eof),
        .ov_frame_len(ov_frame_len), .o_abort(o_abort),
`ifdef DTH_STATS_EN
        .ov_frame_cnt(ov_frame_cnt), .ov_err_cnt(ov_err_cnt),
`endif
        .o_err(o_err)
    );
    // Frame-level reference: what the next output cycle must show for this input word
    task automatic model(input logic rst, input logic wr, input logic [DW:0] d);
        bit emit;
        emit = 0;
        {m.dwr, m.sof, m.eof, m.ab, m.er} = '0;
        if (rst) begin
            in_frame = 0; dropping = 0; len = 0; m = '0; m_fc = 0; m_ec = 0;
            return;
        end
        if (dropping) dropping = wr;
        else if (!in_frame) begin
            if (wr && d[DW]) begin emit = 1; m.sof = 1; len = 1; in_frame = 1; end
            else if (wr) begin m.er = 1; dropping = 1; end
        end else if (!wr) begin
            in_frame = 0; m.ab = 1; m.er = 1;
        end else if (d[DW]) begin
            len++; emit = 1; m.eof = 1; m.len = LW'(len); in_frame = 0; m_fc++;
        end else if (len == ML - 1) begin
            in_frame = 0; dropping = 1; m.ab = 1; m.er = 1;
        end else begin
            len++; emit = 1;
        end
        if (emit) begin m.dwr = 1; m.data = d[DW-1:0]; end
        if (m.er) m_ec++;
    endtask
    task automatic step(input logic rst, input logic wr, input logic [DW:0] d);
        i_rst = rst; i_data_wr = wr; iv_data = d;
        model(rst, wr, d);
        @(posedge i_clk);
        #1;
    endtask
    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = {o_data_wr, o_sof, o_eof, o_abort, o_err, ov_data, ov_frame_len};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got wr/sof/eof/abort/err=%b data=%h len=%0d, want %b data=%h len=%0d",
                     name, {a.dwr, a.sof, a.eof, a.ab, a.er}, a.data, a.len,
                     {e.dwr, e.sof, e.eof, e.ab, e.er}, e.data, e.len);
        end
`ifdef DTH_STATS_EN
        n_vec++;
        if ({ov_frame_cnt, ov_err_cnt} !== {16'(m_fc), 16'(m_ec)}) begin
            n_bad++;
            $display("FAIL %s stats: got frames=%0d errs=%0d, want frames=%0d errs=%0d",
                     name, ov_frame_cnt, ov_err_cnt, m_fc, m_ec);
        end
`endif
    endtask
    function automatic vec_t v(input logic rst, input logic wr, input logic [DW:0] d,
                               input logic [4:0] f, input logic [DW-1:0] data, input logic [LW-1:0] l);
        return {rst, wr, d, f, data, l};
    endfunction
    task automatic hand(input string name, input logic rst, input logic wr, input logic [DW:0] d,
                        input logic [4:0] f, input logic [DW-1:0] data, input logic [LW-1:0] l);
        vec_t t;
        t = v(rst, wr, d, f, data, l);
        step(rst, wr, d);
        check(name, t.e);
    endtask
    initial begin
        // flags column: {data_wr, sof, eof, abort, err}
        tbl = '{
            v(1, 0, 9'h000, 5'b00000, 8'h00, 0),
            v(0, 1, 9'h11A, 5'b11000, 8'h1A, 0), v(0, 1, 9'h02B, 5'b10000, 8'h2B, 0),
            v(0, 1, 9'h13C, 5'b10100, 8'h3C, 3), v(0, 0, 9'h000, 5'b00000, 8'h3C, 3),
            v(0, 1, 9'h1A1, 5'b11000, 8'hA1, 3), v(0, 1, 9'h1A2, 5'b10100, 8'hA2, 2),
            v(0, 1, 9'h1B1, 5'b11000, 8'hB1, 2), v(0, 1, 9'h1B2, 5'b10100, 8'hB2, 2),
            v(0, 0, 9'h000, 5'b00000, 8'hB2, 2),
            v(0, 1, 9'h055, 5'b00001, 8'hB2, 2), v(0, 0, 9'h000, 5'b00000, 8'hB2, 2),
            v(0, 1, 9'h110, 5'b11000, 8'h10, 2), v(0, 1, 9'h011, 5'b10000, 8'h11, 2),
            v(0, 0, 9'h000, 5'b00011, 8'h11, 2),
            v(0, 1, 9'h120, 5'b11000, 8'h20, 2), v(0, 1, 9'h121, 5'b10100, 8'h21, 2),
            v(0, 0, 9'h000, 5'b00000, 8'h21, 2),
            v(0, 1, 9'h130, 5'b11000, 8'h30, 2), v(0, 1, 9'h031, 5'b10000, 8'h31, 2),
            v(0, 1, 9'h032, 5'b10000, 8'h32, 2), v(0, 1, 9'h033, 5'b00011, 8'h32, 2),
            v(0, 1, 9'h034, 5'b00000, 8'h32, 2), v(0, 1, 9'h135, 5'b00000, 8'h32, 2),
            v(0, 0, 9'h000, 5'b00000, 8'h32, 2),
            v(0, 1, 9'h140, 5'b11000, 8'h40, 2), v(0, 1, 9'h041, 5'b10000, 8'h41, 2),
            v(0, 1, 9'h042, 5'b10000, 8'h42, 2), v(0, 1, 9'h143, 5'b10100, 8'h43, 4),
            v(0, 0, 9'h000, 5'b00000, 8'h43, 4),
            v(0, 1, 9'h150, 5'b11000, 8'h50, 4), v(0, 0, 9'h000, 5'b00011, 8'h50, 4)
        };
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].e);
        end
        hand("rst_sof", 0, 1, 9'h160, 5'b11000, 8'h60, 4);
        hand("rst_mid", 0, 1, 9'h061, 5'b10000, 8'h61, 4);
        hand("rst_hit", 1, 1, 9'h062, 5'b00000, 8'h00, 0);
        hand("rst_noab", 0, 0, 9'h000, 5'b00000, 8'h00, 0);
        hand("rst_idle_err1", 0, 1, 9'h063, 5'b00001, 8'h00, 0);
        hand("rst_gap1", 0, 0, 9'h000, 5'b00000, 8'h00, 0);
        hand("rst_idle_err2", 0, 1, 9'h064, 5'b00001, 8'h00, 0);
        hand("rst_gap2", 0, 0, 9'h000, 5'b00000, 8'h00, 0);
        hand("rst_idle_err3", 0, 1, 9'h065, 5'b00001, 8'h00, 0);
        hand("rst_gap3", 0, 0, 9'h000, 5'b00000, 8'h00, 0);
`ifdef DTH_STATS_EN
        n_vec++;
        if (ov_err_cnt !== 16'd3 || ov_frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL err_cnt3: got errs=%0d frames=%0d, want errs=3 frames=0", ov_err_cnt, ov_frame_cnt);
        end
`endif
        for (int i = 0; i < 3000; i++) begin
            logic r, w;
            logic [DW:0] d;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 9) < 8);
            d = {($urandom_range(0, 3) == 0), 8'($urandom)};
            step(r, w, d);
            check($sformatf("rand%0d", i), m);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
